// File: rtl/pcs_rx_pkg.sv
// Shared receive-path definitions: block-type flags, state encodings and
// the CGMII constants used by decoder_comparator and rx_decoder_fsm.
package pcs_rx_pkg;

  // Bit positions of the {D,S,C,T} flags in the 4-bit R_TYPE vector
  localparam int R_TYPE_D = 3;
  localparam int R_TYPE_S = 2;
  localparam int R_TYPE_C = 1;
  localparam int R_TYPE_T = 0;

  // CGMII character codes
  localparam logic [7:0] CGMII_START = 8'hFB;
  localparam logic [7:0] CGMII_TERM  = 8'hFD;
  localparam logic [7:0] CGMII_IDLE  = 8'h07;
  localparam logic [7:0] CGMII_ERROR = 8'hFE;
  localparam logic [7:0] CGMII_SEQ   = 8'h9C;

  // Error block: every lane carries an error control character
  localparam logic [63:0] EBLOCK_R_DATA = {8{CGMII_ERROR}};
  localparam logic [7:0]  EBLOCK_R_CTRL = 8'hFF;

  // Local-fault block: two sequence ordered sets (9C 00 00 01)
  localparam logic [63:0] LBLOCK_R_DATA = {CGMII_SEQ, 8'h00, 8'h00, 8'h01,
                                           CGMII_SEQ, 8'h00, 8'h00, 8'h01};
  localparam logic [7:0]  LBLOCK_R_CTRL = 8'b1000_1000;

  // Receive state encodings as seen on o_state
  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_C    = 3'd1,
    ST_D    = 3'd2,
    ST_T    = 3'd3,
    ST_E    = 3'd4
  } rx_state_e;

  // Classified block type after the one-hot check
  typedef enum logic [2:0] {
    RT_C,
    RT_S,
    RT_D,
    RT_T,
    RT_E
  } rx_type_e;

  // Anything other than exactly one flag set is treated as an error block
  function automatic rx_type_e decode_rtype(input logic [3:0] flags);
    rx_type_e result;
    result = RT_E;
    if (flags == (4'b0001 << R_TYPE_D)) result = RT_D;
    if (flags == (4'b0001 << R_TYPE_S)) result = RT_S;
    if (flags == (4'b0001 << R_TYPE_C)) result = RT_C;
    if (flags == (4'b0001 << R_TYPE_T)) result = RT_T;
    return result;
  endfunction

endpackage

// File: rtl/rx_error_counter.sv
// Saturating errored-block counter; a clear wins over the old value but a
// coincident increment still counts as the first new error.
module rx_error_counter #(
  parameter int LEN_ERR_COUNT = 22
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_increment,
  output logic [LEN_ERR_COUNT-1:0] o_count
);

  localparam logic [LEN_ERR_COUNT-1:0] COUNT_MAX = '1;
  localparam logic [LEN_ERR_COUNT-1:0] COUNT_ONE = LEN_ERR_COUNT'(1);

  logic [LEN_ERR_COUNT-1:0] r_count;

  // Clear-then-count update, holding at all-ones once saturated
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= i_increment ? COUNT_ONE : '0;
    end else if (i_increment && (r_count != COUNT_MAX)) begin
      r_count <= r_count + COUNT_ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rx_decoder_fsm.sv
// Receive control state machine: holds each decoded block for one block
// period so a T block can be judged against the type of the block after it,
// then emits the held block, an error block, or a local-fault block.
module rx_decoder_fsm
  import pcs_rx_pkg::*;
#(
  parameter int LEN_DATA_BLOCK = 64,
  parameter int LEN_CTRL_BLOCK = 8,
  parameter int LEN_ERR_COUNT  = 22
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [LEN_DATA_BLOCK-1:0] i_rx_data,
  input  logic [LEN_CTRL_BLOCK-1:0] i_rx_ctrl,
  input  logic [3:0]                i_rx_type,
  input  logic                      i_block_lock,
  input  logic                      i_hi_ber,
  input  logic                      i_clear_err_count,
  output logic [LEN_DATA_BLOCK-1:0] o_rx_data,
  output logic [LEN_CTRL_BLOCK-1:0] o_rx_ctrl,
  output logic                      o_valid,
  output logic [2:0]                o_state,
  output logic [LEN_ERR_COUNT-1:0]  o_err_count
);

  rx_state_e                 r_state;
  rx_type_e                  r_hold_type;
  logic [LEN_DATA_BLOCK-1:0] r_hold_data;
  logic [LEN_CTRL_BLOCK-1:0] r_hold_ctrl;
  logic                      r_primed;
  logic [LEN_DATA_BLOCK-1:0] r_out_data;
  logic [LEN_CTRL_BLOCK-1:0] r_out_ctrl;
  logic                      r_valid;

  rx_state_e                 w_next_state;
  rx_type_e                  w_in_type;
  logic [LEN_DATA_BLOCK-1:0] w_next_data;
  logic [LEN_CTRL_BLOCK-1:0] w_next_ctrl;
  logic                      w_next_valid;
  logic                      w_link_ok;
  logic                      w_next_is_sc;
  logic                      w_err_inc;

  // Hold stage: the incoming block waits here one enable so its successor's
  // type is known when it is judged; reset drops any held block
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_hold_type <= RT_E;
      r_hold_data <= '0;
      r_hold_ctrl <= '0;
      r_primed    <= 1'b0;
    end else if (i_enable) begin
      r_hold_type <= w_in_type;
      r_hold_data <= i_rx_data;
      r_hold_ctrl <= i_rx_ctrl;
      r_primed    <= 1'b1;
    end
  end

  // State and output registers; the next-state logic already holds values
  // on cycles without an enable
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_out_data <= LBLOCK_R_DATA;
      r_out_ctrl <= LBLOCK_R_CTRL;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_out_data <= w_next_data;
      r_out_ctrl <= w_next_ctrl;
      r_valid    <= w_next_valid;
    end
  end

  // Next state and output block: held type drives the transition, incoming
  // type only matters for validating a held T block
  always_comb begin
    w_next_state = r_state;
    w_next_data  = r_out_data;
    w_next_ctrl  = r_out_ctrl;
    w_next_valid = 1'b0;
    w_err_inc    = 1'b0;
    w_in_type    = decode_rtype(i_rx_type);
    w_link_ok    = i_block_lock && !i_hi_ber;
    w_next_is_sc = (w_in_type == RT_S) || (w_in_type == RT_C);

    if (i_enable) begin
      w_next_valid = r_primed;
      if (!w_link_ok) begin
        w_next_state = ST_INIT;
        w_next_data  = LBLOCK_R_DATA;
        w_next_ctrl  = LBLOCK_R_CTRL;
      end else if (r_primed) begin
        case (r_state)
          ST_D: begin
            if (r_hold_type == RT_D)                       w_next_state = ST_D;
            else if (r_hold_type == RT_T && w_next_is_sc)  w_next_state = ST_T;
            else                                           w_next_state = ST_E;
          end
          ST_E: begin
            if (r_hold_type == RT_C)                       w_next_state = ST_C;
            else if (r_hold_type == RT_D)                  w_next_state = ST_D;
            else if (r_hold_type == RT_T && w_next_is_sc)  w_next_state = ST_T;
            else                                           w_next_state = ST_E;
          end
          default: begin
            if (r_hold_type == RT_C)                       w_next_state = ST_C;
            else if (r_hold_type == RT_S)                  w_next_state = ST_D;
            else                                           w_next_state = ST_E;
          end
        endcase

        if (w_next_state == ST_E) begin
          w_next_data = EBLOCK_R_DATA;
          w_next_ctrl = EBLOCK_R_CTRL;
          w_err_inc   = 1'b1;
        end else begin
          w_next_data = r_hold_data;
          w_next_ctrl = r_hold_ctrl;
        end
      end
    end
  end

  rx_error_counter #(
    .LEN_ERR_COUNT(LEN_ERR_COUNT)
  ) u_err_counter (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (i_enable && i_clear_err_count),
    .i_increment(w_err_inc),
    .o_count    (o_err_count)
  );

  assign o_rx_data = r_out_data;
  assign o_rx_ctrl = r_out_ctrl;
  assign o_valid   = r_valid;
  assign o_state   = r_state;

endmodule

// File: doc/rx_decoder_fsm.md
Name: rx_decoder_fsm

Overview:
- Receive control state machine downstream of decoder_comparator; implements the Clause 82 receive process (RX_INIT/C/D/T/E).
- Holds each decoded block for one block period so T blocks can be validated against the next block's type (R_TYPE_NEXT).
- Passes valid blocks through; replaces invalid ones with EBLOCK_R; forces LBLOCK_R when block lock is lost or hi_ber is set.
- Keeps a saturating errored-block counter.

Parameters:
LEN_DATA_BLOCK, 64, CGMII data width (8 lanes x 8 bits)
LEN_CTRL_BLOCK, 8, CGMII control width (1 bit per lane)
LEN_ERR_COUNT, 22, errored-block counter width

Ports:
i_clock  in  1  block clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  block strobe; one decoded block is presented per asserted cycle
i_rx_data  in  LEN_DATA_BLOCK  decoded CGMII data from decoder_comparator
i_rx_ctrl  in  LEN_CTRL_BLOCK  decoded CGMII control
i_rx_type  in  4  {D,S,C,T} flags from decoder_comparator
i_block_lock  in  1  block lock from the alignment/lock logic
i_hi_ber  in  1  high-BER indication
i_clear_err_count  in  1  synchronous clear of the errored-block counter
o_rx_data  out  LEN_DATA_BLOCK  CGMII data to the RS
o_rx_ctrl  out  LEN_CTRL_BLOCK  CGMII control to the RS
o_valid  out  1  one-cycle pulse per output block
o_state  out  3  current state: INIT=0, C=1, D=2, T=3, E=4
o_err_count  out  LEN_ERR_COUNT  errored-block count

Behaviour:
- Type decode: a type is E unless i_rx_type is exactly one-hot (0000 or multiple bits set -> E).
- Hold stage: on each enabled cycle, capture i_rx_data/i_rx_ctrl/type into hold registers (held type H).
  - In the same cycle, the FSM evaluates H as the current type and the incoming type as NEXT.
  - It registers the output for H.
- Latency: a block presented at enable k is output at the edge of enable k+1, with o_valid=1 for that cycle.
- o_valid=0 until the first block has been captured (primed flag).
- No state, hold or counter changes occur when i_enable=0.
- Link override: if an enabled cycle sees i_block_lock=0 or i_hi_ber=1:
  - state <= INIT and the output is LBLOCK_R;
  - the hold stage still captures;
  - the counter does not change.
- Transitions on each enabled cycle when the link is OK (source state: held type -> next state):
  - INIT: C->C; S->D; else->E.
  - C: C->C; S->D; else->E.
  - D: D->D; T with NEXT in {S,C} ->T; else->E.
  - T: C->C; S->D; else->E.
  - E: C->C; D->D; T with NEXT in {S,C} ->T; else->E.
- Output data per state entered:
  - C/D/T: the held block passes through unchanged.
  - E: EBLOCK_R, data = 8x 8'hFE, ctrl = 8'hFF.
  - INIT: LBLOCK_R, data = {9C,00,00,01,9C,00,00,01}, ctrl = 8'b1000_1000.
- Error counter:
  - +1 on every enabled cycle that enters E while the link is OK.
  - Saturates at 2^LEN_ERR_COUNT-1.
  - i_clear_err_count zeroes it; if clear and increment occur in the same cycle, the result is 1.
- Reset (asynchronous): state=INIT, H=E, primed=0, o_rx_data/o_rx_ctrl=LBLOCK_R, o_valid=0, o_err_count=0.
- Reset mid-packet discards the held block; no partial output follows.

Decomposition:
- Shared package (pcs_rx_pkg):
  - R_TYPE bit indices;
  - state encodings;
  - CGMII constants (FB, FD, 07, FE, 9C);
  - EBLOCK_R and LBLOCK_R data/ctrl constants.
  - decoder_comparator reuses the same constants.
- One sub-module: rx_error_counter (saturating counter with clear priority).

Test Plan:
- Lock=1; types C,C,S,D,D,T(ctrl 8'h01),C -> state path C,C,D,D,D,T,C; data equals the input delayed by 1 enable; o_err_count=0.
- S,D,T followed by D -> the T block is output as 8x FE / ctrl FF; state=E; o_err_count=1; the following D block gives state=D.
- Mid-packet S,D, then i_block_lock=0 for 2 enables -> o_state=0; output 9C000001_9C000001 / 8'h88; counter unchanged; after relock with C -> state C.
- i_rx_type=4'b0000 in state C, then 4'b1010 -> two E outputs; o_err_count=2.
- LEN_ERR_COUNT=2; five E blocks -> o_err_count holds at 3; clear together with an E block -> 1.
- Assert i_reset between D blocks -> o_valid=0, state INIT, LBLOCK_R immediately (asynchronous); the first post-reset block is output one enable later.
